vscale_dmem_responder: RTL and testbench

Data-memory slave answering the core's two-phase dmem port driven by the pipeline control unit. It accepts an address phase in the core's DX stage and completes the data phase in WB. It generates `dmem_wait` from a wait-state counter and flags bad accesses on `dmem_badmem_e`. It applies byte-lane write masks to an internal word array and returns aligned read words. The block sits between the core and the on-chip data RAM in the test harness.

---
 rtl/vscale_dmem_responder_pkg.sv | 14 +
 rtl/vscale_dmem_lane_mask.sv | 21 ++
 rtl/vscale_dmem_responder.sv | 91 +++++++++
 tb/tb_vscale_dmem_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vscale_dmem_responder_pkg.sv
// vscale_dmem_responder_pkg: FSM encodings, dmem size codes and wait-counter width shared by the dmem responder
package vscale_dmem_responder_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2
  } state_t;
  localparam logic [2:0] DMEM_SIZE_B  = 3'd0;
  localparam logic [2:0] DMEM_SIZE_H  = 3'd1;
  localparam logic [2:0] DMEM_SIZE_W  = 3'd2;
  localparam logic [2:0] DMEM_SIZE_BU = 3'd4;
  localparam logic [2:0] DMEM_SIZE_HU = 3'd5;
  localparam int DMEM_WAIT_CNT_WIDTH = 4;
endpackage

// File: rtl/vscale_dmem_lane_mask.sv
// vscale_dmem_lane_mask: size + byte offset to byte enables, with misaligned and illegal-size flags
module vscale_dmem_lane_mask
  import vscale_dmem_responder_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] offset,
  output logic [3:0] byte_en,
  output logic       misaligned,
  output logic       illegal
);
  logic is_b, is_h, is_w;
  // decode the access width, then shift the lane pattern to the byte offset
  always_comb begin
    is_b = size == DMEM_SIZE_B || size == DMEM_SIZE_BU;
    is_h = size == DMEM_SIZE_H || size == DMEM_SIZE_HU;
    is_w = size == DMEM_SIZE_W;
    illegal = !(is_b || is_h || is_w);
    misaligned = (is_h && offset[0]) || (is_w && offset != 2'd0);
    byte_en = is_w ? 4'b1111 : is_h ? 4'b0011 << offset : is_b ? 4'b0001 << offset : 4'b0000;
  end
endmodule

// File: rtl/vscale_dmem_responder.sv
// vscale_dmem_responder: two-phase dmem slave with optional wait states (VSCALE_DMEM_WAIT_EN) and fault reporting
module vscale_dmem_responder
  import vscale_dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dmem_en,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata_delayed,
  output logic [31:0] dmem_rdata_delayed,
  output logic        dmem_wait,
  output logic        dmem_badmem_e
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t state, state_next;
  logic [31:0] addr_q;
  logic wen_q;
  logic [2:0] size_q;
  logic accept, in_wait, fault, misaligned, illegal, out_of_range;
  logic [3:0] byte_en;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH_WORDS];
  assign accept = dmem_en && !in_wait;
  assign idx = addr_q[AW+1:2];
  assign out_of_range = {2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS);
  assign fault = misaligned || illegal || out_of_range;
  vscale_dmem_lane_mask u_lane_mask (
    .size      (size_q),
    .offset    (addr_q[1:0]),
    .byte_en   (byte_en),
    .misaligned(misaligned),
    .illegal   (illegal)
  );
`ifdef VSCALE_DMEM_WAIT_EN
  localparam logic [DMEM_WAIT_CNT_WIDTH-1:0] WAIT_INIT = DMEM_WAIT_CNT_WIDTH'(WAIT_CYCLES);
  logic [DMEM_WAIT_CNT_WIDTH-1:0] cnt;
  assign in_wait = state == ST_WAIT;
  // wait-state counter: loaded on accept, counts down while stalled
  always_ff @(posedge clk) begin
    if (!reset_n) cnt <= '0;
    else if (accept) cnt <= WAIT_INIT;
    else if (in_wait) cnt <= cnt - 1'b1;
  end
  // next state: accept opens a data phase, optionally through WAIT
  always_comb begin
    state_next = accept ? (WAIT_INIT != '0 ? ST_WAIT : ST_DATA)
               : in_wait ? (cnt == DMEM_WAIT_CNT_WIDTH'(1) ? ST_DATA : ST_WAIT)
               : ST_IDLE;
  end
`else
  localparam int unused_wait_cycles = WAIT_CYCLES;
  assign in_wait = 1'b0;
  // next state: every accept completes in the following cycle
  always_comb begin
    state_next = accept ? ST_DATA : ST_IDLE;
  end
`endif
  // state register
  always_ff @(posedge clk) begin
    state <= !reset_n ? ST_IDLE : state_next;
  end
  // capture the address-phase fields on accept
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q <= '0;
      wen_q <= 1'b0;
      size_q <= '0;
    end else if (accept) begin
      addr_q <= dmem_addr;
      wen_q <= dmem_wen;
      size_q <= dmem_size;
    end
  end
  // outputs: stall in WAIT, data and fault only in the completing cycle
  always_comb begin
    dmem_wait = in_wait;
    dmem_badmem_e = state == ST_DATA && fault;
    dmem_rdata_delayed = (state == ST_DATA && !fault) ? mem[idx] : 32'h0;
  end
  // commit enabled store lanes at the edge ending a clean data phase
  always_ff @(posedge clk) begin
    if (reset_n && state == ST_DATA && wen_q && !fault)
      for (int i = 0; i < 4; i++)
        if (byte_en[i]) mem[idx][8*i +: 8] <= dmem_wdata_delayed[8*i +: 8];
  end
endmodule

// File: tb/tb_vscale_dmem_responder.sv
// tb_vscale_dmem_responder: scoreboard bench for the dmem responder (WAIT_CYCLES=3 when VSCALE_DMEM_WAIT_EN is defined)
`timescale 1ns/1ps
module tb_vscale_dmem_responder;
`ifdef VSCALE_DMEM_WAIT_EN
  localparam int WC = 3;
`else
  localparam int WC = 0;
`endif
  localparam int DEPTH = 1024;

  typedef struct {
    int          due;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        bad;
    logic        chk_rd;
    string       tag;
  } ent_t;

  logic clk = 0;
  logic reset_n = 0;
  logic dmem_en = 0;
  logic dmem_wen = 0;
  logic [2:0] dmem_size = 0;
  logic [31:0] dmem_addr = 0;
  logic [31:0] dmem_wdata_delayed = 0;
  logic [31:0] dmem_rdata_delayed;
  logic dmem_wait, dmem_badmem_e;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic mon_on = 0;
  ent_t sb[$];
  logic [31:0] ref_mem [int];

  vscale_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .dmem_en           (dmem_en),
    .dmem_wen          (dmem_wen),
    .dmem_size         (dmem_size),
    .dmem_addr         (dmem_addr),
    .dmem_wdata_delayed(dmem_wdata_delayed),
    .dmem_rdata_delayed(dmem_rdata_delayed),
    .dmem_wait         (dmem_wait),
    .dmem_badmem_e     (dmem_badmem_e)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // store data is presented only during the head entry's data-phase cycle
  initial forever begin
    @(posedge clk);
    #1;
    dmem_wdata_delayed = (sb.size() > 0 && sb[0].due == cyc) ? sb[0].wdata : $urandom;
  end

  always @(negedge clk) begin
    if (mon_on) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        ent_t e;
        e = sb.pop_front();
        chk({e.tag, "_wait"}, 32'(dmem_wait), 32'd0);
        chk({e.tag, "_badmem"}, 32'(dmem_badmem_e), 32'(e.bad));
        if (e.chk_rd) chk({e.tag, "_rdata"}, dmem_rdata_delayed, e.rdata);
      end else if (sb.size() > 0 && sb[0].due > cyc) begin
        chk({sb[0].tag, "_stall"}, 32'(dmem_wait), 32'd1);
      end else begin
        chk("idle_wait", 32'(dmem_wait), 32'd0);
        chk("idle_badmem", 32'(dmem_badmem_e), 32'd0);
      end
    end
  end

  task automatic acc(input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd, input string tag);
    ent_t e;
    int n = 0;
    int idx, nb, off;
    logic mis, ill, oor, flt, ex;
    logic [31:0] old, nw;
    @(negedge clk);
    dmem_en = 1;
    dmem_wen = w;
    dmem_size = sz;
    dmem_addr = a;
    while (dmem_wait && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) chk({tag, "_accept_timeout"}, 32'd1, 32'd0);
    @(posedge clk);
    off = int'(a[1:0]);
    nb = (sz == 3'd2) ? 4 : (sz == 3'd1 || sz == 3'd5) ? 2 : 1;
    ill = (sz == 3'd3 || sz == 3'd6 || sz == 3'd7);
    mis = !ill && (off % nb) != 0;
    oor = a[31:2] >= 30'(DEPTH);
    flt = ill || mis || oor;
    idx = int'(a[31:2]);
    ex = ref_mem.exists(idx);
    old = ex ? ref_mem[idx] : 32'h0;
    e.due = cyc + 1 + WC;
    e.wdata = wd;
    e.rdata = flt ? 32'h0 : old;
    e.bad = flt;
    e.chk_rd = flt || ex;
    e.tag = tag;
    if (w && !flt) begin
      nw = old;
      for (int i = 0; i < 4; i++)
        if (i >= off && i < off + nb) nw[8*i +: 8] = wd[8*i +: 8];
      ref_mem[idx] = nw;
    end
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    dmem_en = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_wait", 32'(dmem_wait), 32'd0);
    chk("reset_badmem", 32'(dmem_badmem_e), 32'd0);
    chk("reset_rdata", dmem_rdata_delayed, 32'd0);
    reset_n = 1;
    @(negedge clk);
    mon_on = 1;
    acc(1, 3'd2, 32'h100, 32'hDEADBEEF, "sw100");
    idle();
    acc(0, 3'd2, 32'h100, 32'h0, "lw100");
    idle();
    drain();
    acc(1, 3'd2, 32'h200, 32'h0, "sw200");
    acc(1, 3'd0, 32'h201, 32'h0000AB00, "sb201");
    acc(0, 3'd2, 32'h200, 32'h0, "lw200");
    idle();
    drain();
    acc(1, 3'd1, 32'h103, 32'hFFFFFFFF, "sh103_mis");
    acc(0, 3'd2, 32'h100, 32'h0, "lw100_after_mis");
    acc(0, 3'd2, 32'h102, 32'h0, "lw102_mis");
    idle();
    drain();
    acc(1, 3'd2, 32'h40, 32'h11, "sw40");
    acc(0, 3'd2, 32'h40, 32'h0, "lw40_b2b");
    idle();
    drain();
    acc(1, 3'd1, 32'h202, 32'h12340000, "sh202");
    acc(0, 3'd5, 32'h202, 32'h0, "lhu202");
    acc(0, 3'd3, 32'h200, 32'h0, "illegal_size");
    acc(1, 3'd2, 32'h1000, 32'h55555555, "sw_oor");
    acc(1, 3'd2, 32'hFFC, 32'hA5A5A5A5, "sw_top");
    acc(0, 3'd2, 32'hFFC, 32'h0, "lw_top");
    acc(0, 3'd2, 32'h1000, 32'h0, "lw_oor");
    idle();
    drain();
    acc(0, 3'd2, 32'h100, 32'h0, "lw_pulse");
    for (int i = 0; i < WC; i++) begin
      @(negedge clk);
      dmem_en = (i % 2) == 0;
      dmem_wen = 1;
      dmem_addr = 32'h100;
    end
    idle();
    drain();
    acc(0, 3'd2, 32'h100, 32'h0, "lw100_after_pulse");
    idle();
    drain();
    acc(1, 3'd2, 32'h80, 32'hCAFEF00D, "sw80");
    idle();
    drain();
    mon_on = 0;
    dmem_en = 1;
    dmem_wen = 1;
    dmem_size = 3'd2;
    dmem_addr = 32'h80;
    @(posedge clk);
    @(negedge clk);
    dmem_en = 0;
    reset_n = 0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_wait", 32'(dmem_wait), 32'd0);
    chk("abort_badmem", 32'(dmem_badmem_e), 32'd0);
    chk("abort_rdata", dmem_rdata_delayed, 32'd0);
    reset_n = 1;
    @(negedge clk);
    mon_on = 1;
    acc(0, 3'd2, 32'h80, 32'h0, "lw80_after_abort");
    idle();
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
